// File: rtl/fp_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : fp_mem_stage
// Description : FP pipeline MEM stage; issues FLW/FSW over a req/ready port,
//               passes arithmetic results through and drives MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_enable_in,
    input  logic        mem_write_in,
    input  logic        wb_enable_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] result_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_enable_out,
    output logic [4:0]  rd_out,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_timeout
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_ACCESS   = 1'b1;
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd;
    logic             r_wb_en;
    logic             w_last;
    logic             w_aligned;

    assign w_last    = (r_cnt == c_TMO_LAST);
    assign w_aligned = (result_in[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid && mem_enable_in && w_aligned) w_state_nxt = S_ACCESS;
            S_ACCESS: if (dmem_ready || w_last)                   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Upstream is released in the completion/abort cycle itself.
    always_comb begin
        stall_out = (r_state == S_ACCESS) && !dmem_ready && !w_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_rd           <= '0;
            r_wb_en        <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_enable_out  <= 1'b0;
            rd_out         <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
            exc_timeout    <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!mem_enable_in) begin
                            wb_valid      <= 1'b1;
                            wb_data       <= result_in;
                            wb_enable_out <= wb_enable_in;
                            rd_out        <= rd_in;
                        end else if (!w_aligned) begin
                            wb_valid       <= 1'b1;
                            exc_misaligned <= 1'b1;
                            wb_enable_out  <= 1'b0;
                            rd_out         <= rd_in;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write_in;
                            dmem_addr  <= result_in;
                            dmem_wdata <= store_data_in;
                            r_rd       <= rd_in;
                            r_wb_en    <= wb_enable_in;
                            r_cnt      <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        rd_out   <= r_rd;
                        if (dmem_we) begin
                            wb_enable_out <= 1'b0;
                            wb_data       <= '0;
                        end else begin
                            wb_enable_out <= r_wb_en;
                            wb_data       <= dmem_rdata;
                        end
                    end else if (w_last) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        exc_timeout   <= 1'b1;
                        wb_enable_out <= 1'b0;
                        rd_out        <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mem_stage
// Description : Directed self-checking bench for fp_mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_enable_in, mem_write_in, wb_enable_in;
    logic [4:0]  rd_in;
    logic [31:0] result_in, store_data_in;
    logic        stall_out, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_enable_out, exc_misaligned, exc_timeout;
    logic [4:0]  rd_out;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_mem_stage #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .mem_enable_in(mem_enable_in), .mem_write_in(mem_write_in),
        .wb_enable_in(wb_enable_in), .rd_in(rd_in), .result_in(result_in),
        .store_data_in(store_data_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_enable_out(wb_enable_out), .rd_out(rd_out),
        .wb_data(wb_data), .exc_misaligned(exc_misaligned), .exc_timeout(exc_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic me, input logic mw, input logic we,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd);
        in_valid = v; mem_enable_in = me; mem_write_in = mw; wb_enable_in = we;
        rd_in = rd; result_in = res; store_data_in = sd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
        n_cmp++;
        if ({stall_out, dmem_req, dmem_we, wb_valid, wb_enable_out, exc_misaligned, exc_timeout} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                {stall_out, dmem_req, dmem_we, wb_valid, wb_enable_out, exc_misaligned, exc_timeout});
        end
        n_cmp++;
        if ({dmem_addr, dmem_wdata, wb_data, rd_out} !== 101'b0) begin
            n_err++; $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h rd=%0d want all 0",
                dmem_addr, dmem_wdata, wb_data, rd_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fadd();
        drive(1, 0, 0, 1, 5'd5, 32'h40400000, 32'h0);
        n_cmp++;
        if (stall_out !== 1'b0) begin n_err++; $display("FAIL fadd_stall: got %b want 0", stall_out); end
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if ({wb_valid, wb_enable_out, rd_out, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h40400000}) begin
            n_err++; $display("FAIL fadd_wb: valid=%b en=%b rd=%0d data=%h want 1 1 5 40400000",
                wb_valid, wb_enable_out, rd_out, wb_data);
        end
        tick();
        n_cmp++;
        if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fadd_pulse: wb_valid=%b want 0", wb_valid); end
    endtask

    task automatic test_load();
        int reqs = 0;
        int stalls = 0;
        drive(1, 1, 0, 1, 5'd7, 32'h00000100, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (dmem_req === 1'b1 && dmem_addr === 32'h100 && dmem_we === 1'b0) reqs++;
            dmem_ready = (k == 2);
            dmem_rdata = (k == 2) ? 32'h3F800000 : 32'hDEADBEEF;
            #1;
            if (stall_out === 1'b1) stalls++;
            tick();
        end
        dmem_ready = 1'b0;
        n_cmp++;
        if (reqs != 3) begin n_err++; $display("FAIL load_req: got %0d req cycles want 3", reqs); end
        n_cmp++;
        if (stalls != 2) begin n_err++; $display("FAIL load_stall: got %0d stall cycles want 2", stalls); end
        n_cmp++;
        if ({dmem_req, wb_valid, wb_enable_out, rd_out, wb_data, exc_misaligned, exc_timeout} !==
            {1'b0, 1'b1, 1'b1, 5'd7, 32'h3F800000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL load_wb: req=%b valid=%b en=%b rd=%0d data=%h exc=%b%b want 0 1 1 7 3f800000 00",
                dmem_req, wb_valid, wb_enable_out, rd_out, wb_data, exc_misaligned, exc_timeout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 0, 5'd2, 32'h00000204, 32'hC0000000);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h204, 32'hC0000000}) begin
            n_err++; $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h want 1 1 204 c0000000",
                dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin n_err++; $display("FAIL store_stall: got %b want 0", stall_out); end
        tick();
        dmem_ready = 1'b0;
        n_cmp++;
        if ({dmem_req, wb_valid, wb_enable_out, wb_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL store_wb: req=%b valid=%b en=%b data=%h want 0 1 0 0",
                dmem_req, wb_valid, wb_enable_out, wb_data);
        end
        drive(1, 0, 0, 1, 5'd3, 32'h3F000000, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if ({wb_valid, wb_enable_out, rd_out, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h3F000000}) begin
            n_err++; $display("FAIL b2b_fadd: valid=%b en=%b rd=%0d data=%h want 1 1 3 3f000000",
                wb_valid, wb_enable_out, rd_out, wb_data);
        end
        tick();
    endtask

    task automatic test_misaligned();
        drive(1, 1, 0, 1, 5'd9, 32'h00000102, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if ({dmem_req, wb_valid, exc_misaligned, exc_timeout, wb_enable_out} !== 5'b01100) begin
            n_err++; $display("FAIL misaligned: req/valid/mis/tmo/en=%b want 01100",
                {dmem_req, wb_valid, exc_misaligned, exc_timeout, wb_enable_out});
        end
        tick();
        n_cmp++;
        if ({wb_valid, exc_misaligned, stall_out} !== 3'b000) begin
            n_err++; $display("FAIL misaligned_clear: valid/mis/stall=%b want 000",
                {wb_valid, exc_misaligned, stall_out});
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int stalls = 0;
        drive(1, 1, 0, 1, 5'd4, 32'h00000300, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        while (dmem_req === 1'b1 && n < 200) begin
            n++;
            if (stall_out === 1'b1) stalls++;
            tick();
        end
        n_cmp++;
        if (n != 64) begin n_err++; $display("FAIL timeout_len: req held %0d cycles want 64", n); end
        n_cmp++;
        if (stalls != 63) begin n_err++; $display("FAIL timeout_stall: got %0d stall cycles want 63", stalls); end
        n_cmp++;
        if ({wb_valid, exc_timeout, exc_misaligned, wb_enable_out} !== 4'b1100) begin
            n_err++; $display("FAIL timeout_wb: valid/tmo/mis/en=%b want 1100",
                {wb_valid, exc_timeout, exc_misaligned, wb_enable_out});
        end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        n_cmp++;
        if ({wb_valid, dmem_req, exc_timeout} !== 3'b000) begin
            n_err++; $display("FAIL late_ready: valid/req/tmo=%b want 000", {wb_valid, dmem_req, exc_timeout});
        end
        // Ready arriving in the 64th request cycle must complete normally.
        drive(1, 1, 0, 1, 5'd6, 32'h00000304, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n = 0;
        for (int c = 1; c <= 64; c++) begin
            if (dmem_req === 1'b1) n++;
            dmem_ready = (c == 64);
            dmem_rdata = 32'h12345678;
            tick();
        end
        dmem_ready = 1'b0;
        n_cmp++;
        if (n != 64) begin n_err++; $display("FAIL edge_req: req held %0d cycles want 64", n); end
        n_cmp++;
        if ({wb_valid, exc_timeout, wb_enable_out, rd_out, wb_data} !==
            {1'b1, 1'b0, 1'b1, 5'd6, 32'h12345678}) begin
            n_err++; $display("FAIL edge_wb: valid=%b tmo=%b en=%b rd=%0d data=%h want 1 0 1 6 12345678",
                wb_valid, exc_timeout, wb_enable_out, rd_out, wb_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int pulses = 0;
        drive(1, 1, 0, 1, 5'd8, 32'h00000400, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if ({dmem_req, stall_out} !== 2'b11) begin
            n_err++; $display("FAIL pre_reset: req/stall=%b want 11", {dmem_req, stall_out});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dmem_req, stall_out} !== 2'b00) begin
            n_err++; $display("FAIL async_reset: req/stall=%b want 00", {dmem_req, stall_out});
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (wb_valid === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL reset_discard: got %0d wb pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_load();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
